rv32im_lsu_ctrl: RTL and testbench
==================================

// Module: rv32im_lsu_ctrl
// PURPOSE
//  Multi-cycle data-memory access sequencer between the rv32im EXU/LSU path and the data bus.
//  Accepts one load/store per handshake and drives a req/gnt/rvalid memory bus.
//  Generates byte enables and write lane replication, and sign/zero-extends read data.
//  Stalls the pipeline until the response returns; one outstanding access maximum.
// PARAMETERS
//  ADDR_WIDTH      32   byte address width
//  DATA_WIDTH      32   data width (fixed 4 byte lanes)
//  TIMEOUT_CYCLES  255  max cycles in REQ+WAIT before forced error; 0 = timeout disabled
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_ni         in   1   reset, asynchronous, active-low
//  req_valid_i    in   1   EXU presents access
//  req_ready_o    out  1   controller can accept (IDLE only)
//  req_we_i       in   1   1=store, 0=load
//  req_size_i     in   2   00 byte, 01 half, 10 word, 11 reserved
//  req_unsigned_i in   1   zero-extend load (LBU/LHU)
//  req_addr_i     in   32  byte address (ALU result)
//  req_wdata_i    in   32  store data (rs2)
//  flush_i        in   1   drop pending response (pipeline redirect)
//  stall_o        out  1   hold pipeline
//  rsp_valid_o    out  1   1-cycle response strobe
//  rsp_rdata_o    out  32  extended load data; 0 for stores
//  rsp_err_o      out  1   bus error / timeout / misalign, qualified by rsp_valid_o
//  mem_req_o      out  1   bus request
//  mem_we_o       out  1   bus write
//  mem_addr_o     out  32  word-aligned address ({addr[31:2],2'b00})
//  mem_be_o       out  4   byte enables
//  mem_wdata_o    out  32  lane-replicated write data
//  mem_gnt_i      in   1   request accepted
//  mem_rvalid_i   in   1   response valid (earliest 1 cycle after gnt)
//  mem_rdata_i    in   32  read data
//  mem_err_i      in   1   bus error, qualified by mem_rvalid_i
// BEHAVIOUR
//  Reset: state=IDLE, mem_req_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, drop flag=0,
//   timeout counter=0; req_ready_o=1. Reset mid-access returns to IDLE immediately and
//   deasserts mem_req_o; late bus responses are ignored.
//  FSM IDLE->REQ->WAIT->RESP->IDLE:
//   IDLE: req_ready_o=1; accept on req_valid_i&~flush_i: latch we/size/unsigned/addr/wdata, ->REQ.
//   REQ: mem_req_o=1; all mem_* outputs stable until mem_gnt_i; on gnt ->WAIT.
//   WAIT: on mem_rvalid_i capture data, rsp_err=mem_err_i, ->RESP. rvalid outside WAIT ignored.
//   RESP: rsp_valid_o=1 for exactly one cycle (0 if drop flag set), clear drop flag, ->IDLE.
//  Zero-wait bus: accept at cycle N, rsp_valid_o at cycle N+3; next accept at N+4.
//  stall_o = (IDLE & req_valid_i) | REQ | WAIT; 0 in RESP.
//  Byte enables: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111.
//  Write data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
//  Load: shift rdata right by 8*addr[1:0] (half by 16*addr[1]); sign-extend from bit 7/15
//   unless unsigned; word passes through.
//  Timeout: counter cleared at accept, counts in REQ/WAIT; at TIMEOUT_CYCLES ->RESP with
//   rsp_err_o=1, rsp_rdata_o=0, mem_req_o dropped.
//  flush_i in REQ/WAIT/RESP: sets drop flag; bus transaction still completes (stores commit);
//   rsp_valid_o suppressed. flush_i in IDLE blocks acceptance that cycle.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1, word with addr[1:0]!=0, or size=11
//   -> no bus request; IDLE->RESP directly, rsp_err_o=1, rsp_rdata_o=0 (rsp at N+1).
//  Undefined: low address bits below access size ignored (forced alignment); size=11 treated
//   as word; rsp_err_o only from mem_err_i or timeout.
// TESTING
//  LW addr 0x100, gnt same cycle, rvalid next with 0xDEADBEEF -> rsp at N+3, rdata 0xDEADBEEF, err 0.
//  LB addr 0x103, rdata 0x80FF_FFFF -> be 4'b1000, rdata 0xFFFFFF80; LBU -> 0x00000080.
//  SH addr 0x202, wdata 0x1234ABCD -> mem_be 4'b1100, mem_wdata 0xABCDABCD, we=1, rdata 0.
//  gnt withheld 5 cycles -> mem_req/addr/be stable all 5 cycles, rsp at N+8.
//  No gnt, TIMEOUT_CYCLES=4 -> rsp_err_o=1 and mem_req_o low at end of the 4th REQ cycle.
//  LW addr 0x101: with LSU_MISALIGN_TRAP_EN err at N+1, no mem_req; without, addr 0x100 issued.

Source files
------------

// File: rtl/rv32im_lsu_ctrl.sv
// rv32im_lsu_ctrl: sequences a single load or store from the execute stage onto
// a req/gnt/rvalid data bus. Only one access can be outstanding at a time.
// The block generates byte enables, replicates write data across lanes, and
// extends load data. A bus watchdog turns a hung access into an error response.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
// A trapped access never reaches the bus. When the macro is undefined, the low
// address bits below the access size are ignored.
module rv32im_lsu_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i
);

  // The counter is just wide enough to reach TIMEOUT_CYCLES. A value of 0
  // disables the watchdog.
  localparam int          CW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    drop_q, drop_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           cnt_inc;
  logic                    to_hit;
  logic                    misalign;

  // Select the addressed lane and extend it. Size 11 falls through to word.
  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] off);
    logic [31:0] sh;
    logic [31:0] r;
    sh = '0;
    r  = d;
    case (sz)
      2'b00: begin
        sh = d >> {off, 3'b000};
        r  = {{24{sh[7] & ~uns}}, sh[7:0]};
      end
      2'b01: begin
        sh = d >> {off[1], 4'b0000};
        r  = {{16{sh[15] & ~uns}}, sh[15:0]};
      end
      default: r = d;
    endcase
    return r;
  endfunction

  // Detect misaligned requests at the point of acceptance (trap build only).
  always_comb begin
    misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_size_i)
      2'b01:   misalign = req_addr_i[0];
      2'b10:   misalign = |req_addr_i[1:0];
      2'b11:   misalign = 1'b1;
      default: misalign = 1'b0;
    endcase
`endif
  end

  assign cnt_inc = cnt_q + 1'b1;
  assign to_hit  = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIM);

  // Next-state logic and request/response capture.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && !flush_i) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          cnt_d   = '0;
          drop_d  = 1'b0;
          if (misalign) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (flush_i) drop_d = 1'b1;
        // The watchdog beats a grant that arrives in the expiry cycle. Once the
        // request is abandoned, no bus response is expected.
        if (to_hit) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (mem_gnt_i) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush_i) drop_d = 1'b1;
        if (mem_rvalid_i) begin
          state_d = S_RESP;
          err_d   = mem_err_i;
          rdata_d = we_q ? '0 : load_ext(mem_rdata_i, size_q, uns_q, addr_q[1:0]);
        end else if (to_hit) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: begin
        drop_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and capture registers. Reset abandons any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  // Drive the bus from the latched request, so the bus stays stable until gnt.
  always_comb begin
    mem_be_o    = 4'b1111;
    mem_wdata_o = wdata_q;
    case (size_q)
      2'b00: begin
        mem_be_o    = 4'b0001 << addr_q[1:0];
        mem_wdata_o = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        mem_be_o    = addr_q[1] ? 4'b1100 : 4'b0011;
        mem_wdata_o = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign mem_req_o   = (state_q == S_REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  assign req_ready_o = (state_q == S_IDLE);
  assign stall_o     = ((state_q == S_IDLE) && req_valid_i) || (state_q == S_REQ) ||
                       (state_q == S_WAIT);
  // A flush in the response cycle squashes that response as well.
  assign rsp_valid_o = (state_q == S_RESP) && !drop_q && !flush_i;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_rv32im_lsu_ctrl.sv
// Bench for rv32im_lsu_ctrl. Mixes directed and random accesses and checks
// every cycle against an arithmetic reference model.
module tb_rv32im_lsu_ctrl;
  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_we_i, req_unsigned_i, flush_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        req_ready_o, stall_o, rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_rdata_i;

  int n_cmp = 0;
  int n_err = 0;

  rv32im_lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .flush_i(flush_i), .stall_o(stall_o),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference load result, computed with plain arithmetic.
  function automatic logic [31:0] exp_load(input logic [31:0] rd, input int sz,
                                           input bit uns, input int off);
    logic [31:0] v;
    if (sz == 0) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (rd >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Runs one access end to end.
  // gnt_dly < 0 means the bus never grants; rv_dly < 0 means it never responds.
  task automatic run_txn(input bit we, input int sz, input bit uns, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input bit berr,
                         input int gnt_dly, input int rv_dly, input bit do_flush);
    int off, esz, t_gnt, t_rv, t_resp, t_req_end, flush_t;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd;
    bit e_err, mis, drop, noise;
    off = int'(addr[1:0]);
    esz = (sz == 3) ? 2 : sz;
    e_be = (esz == 0) ? 4'(1 << off) : (esz == 1) ? ((off >= 2) ? 4'hC : 4'h3) : 4'hF;
    e_wd = (esz == 0) ? (wd & 32'hFF) * 32'h0101_0101 :
           (esz == 1) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (sz == 1 && (off % 2) == 1) || (sz == 2 && off != 0) || (sz == 3);
`endif
    t_gnt = (gnt_dly < 0 || mis) ? 1000 : gnt_dly + 1;
    t_rv  = (rv_dly < 0 || t_gnt == 1000) ? 1000 : t_gnt + 1 + rv_dly;
    if (mis) begin
      t_resp = 1; t_req_end = 0; e_err = 1'b1; e_rd = '0;
    end else if (t_gnt >= TO) begin
      t_resp = TO + 1; t_req_end = TO; e_err = 1'b1; e_rd = '0;
    end else if (t_rv > TO) begin
      t_resp = TO + 1; t_req_end = t_gnt; e_err = 1'b1; e_rd = '0;
    end else begin
      t_resp = t_rv + 1; t_req_end = t_gnt; e_err = berr;
      e_rd = we ? 32'h0 : exp_load(rd, esz, uns, off);
    end
    flush_t = (do_flush && t_resp > 1) ? $urandom_range(t_resp - 1, 1) : 0;
    drop = 1'b0;

    req_valid_i = 1'b1; req_we_i = we; req_size_i = 2'(sz); req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wd; flush_i = 1'b0;
    @(negedge clk_i);
    chk("accept_ready", {31'b0, req_ready_o}, 32'd1);
    chk("accept_stall", {31'b0, stall_o}, 32'd1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; req_we_i = $urandom; req_size_i = 2'($urandom);
    req_addr_i = $urandom; req_wdata_i = $urandom; req_unsigned_i = $urandom;

    for (int t = 1; t <= t_resp; t++) begin
      noise        = (t < t_gnt) && ($urandom_range(3, 0) == 0);
      mem_gnt_i    = (t == t_gnt);
      mem_rvalid_i = (t == t_rv) || noise;
      mem_rdata_i  = (t == t_rv) ? rd : $urandom;
      mem_err_i    = (t == t_rv) ? berr : 1'b1;
      flush_i      = (t == flush_t);
      if (t == flush_t) drop = 1'b1;
      @(negedge clk_i);
      chk("mem_req", {31'b0, mem_req_o}, {31'b0, (t <= t_req_end)});
      if (t <= t_req_end) begin
        chk("mem_addr", mem_addr_o, {addr[31:2], 2'b00});
        chk("mem_be", {28'b0, mem_be_o}, {28'b0, e_be});
        chk("mem_we", {31'b0, mem_we_o}, {31'b0, we});
        if (we) chk("mem_wdata", mem_wdata_o, e_wd);
      end
      chk("stall", {31'b0, stall_o}, {31'b0, (t < t_resp)});
      chk("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, (t == t_resp) && !drop});
      if (t == t_resp && !drop) begin
        chk("rsp_rdata", rsp_rdata_o, e_rd);
        chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, e_err});
      end
      @(posedge clk_i); #1;
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; flush_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0; flush_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", {31'b0, req_ready_o}, 32'd1);
    chk("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err_o}, 32'd0);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Directed cases.
    run_txn(0, 2, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0);   // LW, zero-wait bus
    run_txn(0, 0, 0, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 0, 0, 0);   // LB
    run_txn(0, 0, 1, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 0, 0, 0);   // LBU
    run_txn(1, 1, 0, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 0, 1, 0); // SH
    run_txn(0, 1, 0, 32'h202, 32'h0, 32'h9234_0000, 0, 5, 0, 0);   // gnt withheld 5
    run_txn(0, 2, 0, 32'h300, 32'h0, 32'h0, 0, -1, 0, 0);          // timeout in REQ
    run_txn(1, 2, 0, 32'h304, 32'h55, 32'h0, 0, 1, -1, 0);         // timeout in WAIT
    run_txn(0, 2, 0, 32'h101, 32'h0, 32'h1357_9BDF, 0, 0, 0, 0);   // misaligned LW
    run_txn(0, 1, 1, 32'h401, 32'h0, 32'hF00D_8001, 0, 0, 0, 0);   // misaligned LHU
    run_txn(0, 3, 0, 32'h500, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 0);   // reserved size
    run_txn(0, 0, 0, 32'h600, 32'h0, 32'h0000_0011, 1, 1, 2, 0);   // bus error
    run_txn(0, 2, 0, 32'h700, 32'h0, 32'h1111_2222, 0, 1, 1, 1);   // flushed

    // A flush in IDLE blocks acceptance for that cycle.
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h800;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    chk("idle_flush_ready", {31'b0, req_ready_o}, 32'd1);
    chk("idle_flush_mem_req", {31'b0, mem_req_o}, 32'd0);
    @(posedge clk_i); #1;

    // A reset in mid-access returns to IDLE, and a late response is ignored.
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h900;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("mid_mem_req", {31'b0, mem_req_o}, 32'd1);
    rst_ni = 1'b0; #1;
    chk("mid_rst_mem_req", {31'b0, mem_req_o}, 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hABAB_ABAB;
    @(negedge clk_i);
    chk("late_rvalid_rsp", {31'b0, rsp_valid_o}, 32'd0);
    chk("late_rvalid_ready", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk_i); #1 mem_rvalid_i = 1'b0;
    @(negedge clk_i);
    chk("late_rvalid_stay", {31'b0, rsp_valid_o}, 32'd0);
    @(posedge clk_i); #1;

    // Random accesses. Delays are kept short enough that the watchdog never fires.
    for (int i = 0; i < 60; i++) begin
      run_txn($urandom_range(1, 0), $urandom_range(3, 0), $urandom_range(1, 0), $urandom,
              $urandom, $urandom, ($urandom_range(7, 0) == 0), $urandom_range(2, 0),
              $urandom_range(2, 0), ($urandom_range(5, 0) == 0));
      if ($urandom_range(3, 0) == 0) begin
        @(negedge clk_i);
        chk("gap_ready", {31'b0, req_ready_o}, 32'd1);
        @(posedge clk_i); #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
